// File: rtl/output_fader.sv
// Stereo mute/fade/boost stage: per-frame gain ramp, 0..3-bit boost with saturation,
// and a clip flag held for CLIP_HOLD frames after the last saturating sample.
module output_fader #(
   parameter int BITSIZE   = 16,
   parameter int STEP      = 64,
   parameter int CLIP_HOLD = 24000
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      sample_en,
   input  logic                      mute,
   input  logic [1:0]                boost,
   input  logic signed [BITSIZE-1:0] in_l,
   input  logic signed [BITSIZE-1:0] in_r,
   output logic signed [BITSIZE-1:0] out_l,
   output logic signed [BITSIZE-1:0] out_r,
   output logic                      out_valid,
   output logic                      clip,
   output logic                      silent
);

   localparam int PW = BITSIZE + 17;
   localparam int SW = PW + 3;
   localparam int CW = (CLIP_HOLD > 1) ? $clog2(CLIP_HOLD + 1) : 1;

   localparam logic [1:0] S_MUTED     = 2'd0;
   localparam logic [1:0] S_RAMP_UP   = 2'd1;
   localparam logic [1:0] S_UNITY     = 2'd2;
   localparam logic [1:0] S_RAMP_DOWN = 2'd3;

   localparam logic [15:0] GAIN_UNITY = 16'h8000;
   localparam logic [16:0] STEP_W     = 17'(STEP);

   localparam logic signed [SW-1:0] SAT_MAX = SW'((64'sd1 <<< (BITSIZE - 1)) - 64'sd1);
   localparam logic signed [SW-1:0] SAT_MIN = ~SAT_MAX;

   function automatic logic sat_hit(input logic signed [SW-1:0] v);
      return (v > SAT_MAX) || (v < SAT_MIN);
   endfunction

   function automatic logic signed [BITSIZE-1:0] saturate(input logic signed [SW-1:0] v);
      if (v > SAT_MAX)
         return SAT_MAX[BITSIZE-1:0];
      else if (v < SAT_MIN)
         return SAT_MIN[BITSIZE-1:0];
      else
         return v[BITSIZE-1:0];
   endfunction

   logic [1:0]  state, state_nxt;
   logic [15:0] gain, gain_nxt;
   logic [16:0] gain_sum;
   logic [15:0] gain_up, gain_dn;

   assign gain_sum = {1'b0, gain} + STEP_W;
   assign gain_up  = (gain_sum >= {1'b0, GAIN_UNITY}) ? GAIN_UNITY : gain_sum[15:0];
   assign gain_dn  = (gain > STEP_W[15:0]) ? (gain - STEP_W[15:0]) : 16'd0;

   // A direction reversal mid-ramp holds the gain for that one frame.
   always_comb begin
      state_nxt = state;
      gain_nxt  = gain;
      case (state)
         S_MUTED: begin
            if (!mute) begin
               gain_nxt  = gain_up;
               state_nxt = (gain_up == GAIN_UNITY) ? S_UNITY : S_RAMP_UP;
            end
         end
         S_RAMP_UP: begin
            if (mute) begin
               state_nxt = S_RAMP_DOWN;
            end else begin
               gain_nxt = gain_up;
               if (gain_up == GAIN_UNITY)
                  state_nxt = S_UNITY;
            end
         end
         S_UNITY: begin
            if (mute) begin
               gain_nxt  = gain_dn;
               state_nxt = (gain_dn == 16'd0) ? S_MUTED : S_RAMP_DOWN;
            end
         end
         default: begin
            if (!mute) begin
               state_nxt = S_RAMP_UP;
            end else begin
               gain_nxt = gain_dn;
               if (gain_dn == 16'd0)
                  state_nxt = S_MUTED;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_MUTED;
         gain  <= 16'd0;
      end else if (sample_en) begin
         state <= state_nxt;
         gain  <= gain_nxt;
      end
   end

   assign silent = (state == S_MUTED);

   // ---- stage p1: gain multiply, using the gain in force before this strobe ----
   logic signed [PW-1:0] prod_l_p1, prod_r_p1;
   logic [1:0]           boost_p1;
   logic                 vld_p1;

   always_ff @(posedge clk) begin
      if (rst)
         vld_p1 <= 1'b0;
      else
         vld_p1 <= sample_en;
   end

   always_ff @(posedge clk) begin
      if (sample_en) begin
         prod_l_p1 <= PW'(in_l) * PW'($signed({1'b0, gain}));
         prod_r_p1 <= PW'(in_r) * PW'($signed({1'b0, gain}));
         boost_p1  <= boost;
      end
   end

   // ---- stage p2: floor-scale by 2^-15, boost, saturate, register outputs ----
   logic signed [SW-1:0] ext_l, ext_r, sh_l, sh_r;
   logic                 sat_any;

   assign ext_l   = $signed({{3{prod_l_p1[PW-1]}}, prod_l_p1}) >>> 15;
   assign ext_r   = $signed({{3{prod_r_p1[PW-1]}}, prod_r_p1}) >>> 15;
   assign sh_l    = ext_l <<< boost_p1;
   assign sh_r    = ext_r <<< boost_p1;
   assign sat_any = sat_hit(sh_l) || sat_hit(sh_r);

   always_ff @(posedge clk) begin
      if (rst) begin
         out_l     <= '0;
         out_r     <= '0;
         out_valid <= 1'b0;
      end else begin
         out_valid <= vld_p1;
         if (vld_p1) begin
            out_l <= saturate(sh_l);
            out_r <= saturate(sh_r);
         end
      end
   end

   // Clip hold counts frames, not clocks; a fresh saturation always reloads.
   logic [CW-1:0] hold_cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         hold_cnt <= '0;
         clip     <= 1'b0;
      end else if (vld_p1 && sat_any) begin
         hold_cnt <= CW'(CLIP_HOLD);
         clip     <= 1'b1;
      end else if (sample_en && (hold_cnt != '0)) begin
         hold_cnt <= hold_cnt - CW'(1);
         if (hold_cnt == CW'(1))
            clip <= 1'b0;
      end
   end

endmodule

// File: tb/tb_output_fader.sv
// Self-checking bench for output_fader: per-cycle comparison against a behavioural
// gain/pipeline model, plus directed literal expectations for ramps, boost, clip and reset.
module tb_output_fader;

   localparam int BITSIZE = 16;
   localparam int STEP    = 64;
   localparam int HOLD    = 20;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                      rst       = 1'b1;
   logic                      sample_en = 1'b0;
   logic                      mute      = 1'b1;
   logic [1:0]                boost     = 2'd0;
   logic signed [BITSIZE-1:0] in_l      = '0;
   logic signed [BITSIZE-1:0] in_r      = '0;
   logic signed [BITSIZE-1:0] out_l, out_r;
   logic                      out_valid, clip, silent;

   output_fader #(.BITSIZE(BITSIZE), .STEP(STEP), .CLIP_HOLD(HOLD)) dut (
      .clk(clk), .rst(rst), .sample_en(sample_en), .mute(mute), .boost(boost),
      .in_l(in_l), .in_r(in_r), .out_l(out_l), .out_r(out_r),
      .out_valid(out_valid), .clip(clip), .silent(silent)
   );

   int n_tests = 0;
   int n_fail  = 0;
   bit chk_en  = 1'b0;

   task automatic check(input string name, input longint act, input longint exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference: out = sat(floor(x * g / 32768) * 2^b)
   function automatic int ref_out(input int x, input int g, input int b, output bit sat);
      longint p, q;
      p = longint'(x) * g;
      q = p / 32768;
      if ((p % 32768 != 0) && (p < 0)) q = q - 1;
      q = q * (64'sd1 << b);
      sat = (q > 32767) || (q < -32768);
      if (q > 32767)  q = 32767;
      if (q < -32768) q = -32768;
      return int'(q);
   endfunction

   // Behavioural model: gain moves toward the mute target; a reversal mid-ramp holds one frame.
   int g = 0;
   bit dir_up = 1'b0;
   bit m_vld1 = 1'b0, m_valid = 1'b0, e_sat = 1'b0, reload = 1'b0;
   int e_l = 0, e_r = 0, m_l = 0, m_r = 0, m_cnt = 0;
   bit s1, s2;

   always @(posedge clk) begin
      if (rst) begin
         g = 0; dir_up = 1'b0; m_vld1 = 1'b0; m_valid = 1'b0;
         m_l = 0; m_r = 0; m_cnt = 0;
      end else begin
         reload  = 1'b0;
         m_valid = m_vld1;
         if (m_vld1) begin
            m_l = e_l; m_r = e_r;
            if (e_sat) begin m_cnt = HOLD; reload = 1'b1; end
         end
         m_vld1 = sample_en;
         if (sample_en) begin
            e_l   = ref_out(int'(in_l), g, int'(boost), s1);
            e_r   = ref_out(int'(in_r), g, int'(boost), s2);
            e_sat = s1 | s2;
            if (!reload && m_cnt > 0) m_cnt = m_cnt - 1;
            if (!mute) begin
               if (g == 0 || g == 32768 || dir_up) g = (g + STEP > 32768) ? 32768 : g + STEP;
               dir_up = 1'b1;
            end else begin
               if (g == 0 || g == 32768 || !dir_up) g = (g - STEP < 0) ? 0 : g - STEP;
               dir_up = 1'b0;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("cmp_valid",  out_valid, m_valid);
         check("cmp_out_l",  out_l, m_l);
         check("cmp_out_r",  out_r, m_r);
         check("cmp_clip",   clip, (m_cnt != 0));
         check("cmp_silent", silent, (g == 0));
      end
   end

   logic signed [BITSIZE-1:0] cap_l, cap_r;
   logic cap_valid, cap_pre, cap_clip, cap_silent;

   // Called and returns at posedge+1; captures outputs on the cycle out_valid is due.
   task automatic strobe(input int l, input int r, input bit m, input int b, input int extra);
      sample_en = 1'b1; in_l = 16'(l); in_r = 16'(r); mute = m; boost = 2'(b);
      @(posedge clk); #1;
      sample_en = 1'b0;
      cap_pre = out_valid;
      @(posedge clk); #1;
      cap_l = out_l; cap_r = out_r; cap_valid = out_valid;
      cap_clip = clip; cap_silent = silent;
      @(posedge clk); #1;
      repeat (extra) begin @(posedge clk); #1; end
   endtask

   task automatic do_reset();
      rst = 1'b1; sample_en = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   function automatic int rnd_sample();
      int k;
      k = int'($urandom_range(0, 7));
      if (k == 0) return -32768;
      if (k == 1) return 32767;
      return int'($urandom_range(0, 65535)) - 32768;
   endfunction

   logic signed [BITSIZE-1:0] prev_l;
   bit rmute;
   int rboost;

   initial begin
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      chk_en = 1'b1;

      // Reset state
      check("rst_out_l", out_l, 0);
      check("rst_valid", out_valid, 0);
      check("rst_clip", clip, 0);
      check("rst_silent", silent, 1);

      // Ramp up from silence
      prev_l = '0;
      for (int f = 1; f <= 520; f++) begin
         strobe(1000, 1000, 1'b0, 0, int'($urandom_range(0, 2)));
         if (f == 1) begin
            check("t1_first", cap_l, 0);
            check("t1_valid", cap_valid, 1);
            check("t1_silent_fall", cap_silent, 0);
         end
         if (f == 2)   check("t1_second", cap_l, 1);
         if (f == 513) check("t1_f513", cap_l, 1000);
         if (f >= 514) check("t1_unity", cap_l, 1000);
         check("t1_mono", (cap_l >= prev_l), 1);
         prev_l = cap_l;
      end

      // Full-scale pass-through at unity
      for (int f = 0; f < 3; f++) begin
         strobe(-32768, 32767, 1'b0, 0, 0);
         check("t2_l", cap_l, -32768);
         check("t2_r", cap_r, 32767);
         check("t2_clip", cap_clip, 0);
         check("t2_pre", cap_pre, 0);
         check("t2_valid", cap_valid, 1);
      end

      // Boost saturation and clip hold
      strobe(20000, -20000, 1'b0, 1, 0);
      check("t3_l", cap_l, 32767);
      check("t3_r", cap_r, -32768);
      check("t3_clip_set", cap_clip, 1);
      for (int j = 1; j <= HOLD + 2; j++) begin
         strobe(0, 0, 1'b0, 1, int'($urandom_range(0, 2)));
         check("t3_clip_hold", cap_clip, (j < HOLD));
      end

      // Half-gain mute, floor rounding, fade to silence
      do_reset();
      for (int f = 0; f < 256; f++) strobe(1000, 0, 1'b0, 0, 0);
      strobe(1000, -3, 1'b1, 0, 0);
      check("t4_half", cap_l, 500);
      check("t6_floor", cap_r, -2);
      for (int j = 1; j <= 256; j++) begin
         strobe(1000, 0, 1'b1, 0, int'($urandom_range(0, 1)));
         if (j == 1) check("t4_hold", cap_l, 500);
         if (j == 2) check("t4_down", cap_l, 498);
         check("t4_silent", cap_silent, (j == 256));
      end
      strobe(1000, 1000, 1'b1, 0, 0);
      check("t4_zero", cap_l, 0);

      // Reset while a frame is in flight during a ramp
      do_reset();
      for (int f = 0; f < 5; f++) strobe(1000, 1000, 1'b0, 0, 0);
      sample_en = 1'b1;
      @(posedge clk); #1;
      sample_en = 1'b0; rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("t5_valid", out_valid, 0);
      check("t5_out_l", out_l, 0);
      check("t5_out_r", out_r, 0);
      check("t5_clip", clip, 0);
      check("t5_silent", silent, 1);
      @(posedge clk); #1;
      check("t5_valid_next", out_valid, 0);

      // Randomised traffic against the model
      rmute = 1'b0; rboost = 0;
      for (int f = 0; f < 3000; f++) begin
         if ($urandom_range(0, 199) == 0) rmute = ~rmute;
         if ($urandom_range(0, 31) == 0) rboost = int'($urandom_range(0, 3));
         if ($urandom_range(0, 599) == 0) do_reset();
         strobe(rnd_sample(), rnd_sample(), rmute, rboost, int'($urandom_range(0, 3)));
      end

      repeat (4) @(posedge clk);
      #1;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/output_fader.md
Name: output_fader

Overview:
Stereo click-free mute, fade and boost stage between the routing matrix outputs (out_l/out_r) and the I2S transmitter. It applies a per-sample gain ramp on mute/unmute, an optional 0..3-bit left-shift boost with saturation, and a held clip indicator for the LED or CPU. It runs in the OSC domain; the frame strobe is produced upstream from a synchronised DACLRC edge.

Parameters:
BITSIZE, 16, sample width (signed two's complement)
STEP, 64, gain increment/decrement per frame; unity gain is 32768, so the default ramp is 512 frames (~10.7 ms at 48 kHz)
CLIP_HOLD, 24000, number of frames the clip flag stays high after the last saturating sample

Ports:
clk  in  1  system clock (OSC, 49.152 MHz)
rst  in  1  synchronous active-high reset
sample_en  in  1  one-cycle strobe per stereo frame; minimum spacing 3 clk
mute  in  1  level: 1 = fade to silence, 0 = fade to unity
boost  in  2  left-shift amount applied after gain (0..3)
in_l  in  BITSIZE  left sample (signed)
in_r  in  BITSIZE  right sample (signed)
out_l  out  BITSIZE  processed left sample, registered
out_r  out  BITSIZE  processed right sample, registered
out_valid  out  1  one-cycle pulse when out_l/out_r update
clip  out  1  held saturation indicator
silent  out  1  high while the state machine is in MUTED

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high, ports named clk and rst.
- Reset values: gain=0, state=MUTED, out_l=out_r=0, out_valid=0, clip=0, hold counter=0, pipeline valid bits=0, silent=1.
- rst has priority over sample_en. Asserting rst mid-ramp or mid-pipeline discards any in-flight samples; no out_valid is produced for them.
- Gain register: unsigned 16 bits, range 0..32768. It changes only on a clk where sample_en=1.
- State machine, evaluated on sample_en:
  - MUTED (gain=0): mute=0 -> RAMP_UP.
  - RAMP_UP: gain = min(gain+STEP, 32768); reaching 32768 -> UNITY; mute=1 -> RAMP_DOWN with no gain change that frame.
  - UNITY: mute=1 -> RAMP_DOWN.
  - RAMP_DOWN: gain = max(gain-STEP, 0); reaching 0 -> MUTED; mute=0 -> RAMP_UP with no gain change that frame.
  - mute is sampled only at sample_en. Changes between strobes take effect at the next strobe.
- Gain used for each frame: the value of the gain register before that strobe's update. Consequently the first frame after leaving MUTED outputs 0.
- Pipeline:
  - Stage 1 (on sample_en): register p = in × {1'b0, gain}, signed, BITSIZE+17 bits, per channel; also register boost.
  - Stage 2: s = (p >>> 15) <<< boost.
  - Saturate s to [-2^(BITSIZE-1), 2^(BITSIZE-1)-1], register to out_l/out_r, pulse out_valid.
  - Latency: out_valid occurs 2 clk after sample_en.
- Arithmetic: the shift truncates toward -inf, so in=-3 at gain 16384 gives -2. At gain 32768 with boost=0, output equals input bit-exactly, including -2^(BITSIZE-1).
- Clip:
  - On an out_valid where either channel saturated, clip=1 and the hold counter loads CLIP_HOLD.
  - On each later sample_en the counter decrements while nonzero; clip drops when it reaches 0.
  - A new saturation reloads the counter. If saturation and decrement coincide, the reload wins.
- silent: combinational from state==MUTED. Outputs hold their last value between out_valid pulses.

Test Plan:
1. rst, then mute=0, in_l=in_r=1000, one strobe every 1024 clk. Required: first out_l=0, second=1, out_l monotonic non-decreasing, state UNITY after 512 strobes, out_l=1000 from frame 514 on, silent falls after the first strobe.
2. UNITY, boost=0, in_l=-32768, in_r=32767. Required: out_l=-32768, out_r=32767, clip stays 0, out_valid exactly 2 clk after each strobe.
3. UNITY, boost=1, in_l=20000, in_r=-20000 for one frame then 0. Required: out_l=32767, out_r=-32768, clip=1 for exactly CLIP_HOLD further strobes, then 0.
4. Ramp up to gain 16384 (256 strobes), assert mute, in_l=1000. Required: next out_l=500, gain then decreasing by 64 per frame, out_l=0 and silent=1 once gain reaches 0 (256 strobes later).
5. Assert rst for 1 clk during RAMP_UP, with a strobe issued 1 clk earlier. Required: no out_valid for that frame, out_l=out_r=0, clip=0, silent=1 on the following clk.
6. Gain 16384, in_l=-3, boost=0. Required: out_l=-2 (floor rounding).
